// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment display scanner.
// Drives DigitCount common-anode digits one at a time from a packed hex value.
// It supports per-digit enables, leading-zero suppression and a 16-level
// brightness duty. All inputs are captured once per frame, so a value that
// changes mid-frame is never shown torn across the digits.
module seven_segment_scanner #(
  parameter  int DigitCount = 4,
  parameter  int ScanCycles = 100000,
  localparam int SelW       = $clog2(DigitCount),
  localparam int CntW       = $clog2(ScanCycles)
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [4*DigitCount-1:0] Value,
  input  logic [DigitCount-1:0]   DpIn,
  input  logic [DigitCount-1:0]   DigitEnable,
  input  logic                    LeadingZeroBlank,
  input  logic [3:0]              Brightness,
  output logic [DigitCount-1:0]   AN,
  output logic [6:0]              Seg,
  output logic                    Dp,
  output logic [SelW-1:0]         Selector,
  output logic                    FrameDone
);

  localparam logic [SelW-1:0] LastSel   = SelW'(DigitCount - 1);
  localparam logic [CntW-1:0] LastDwell = CntW'(ScanCycles - 1);

  logic                    r_running;
  logic [CntW-1:0]         r_dwell;
  logic [SelW-1:0]         r_sel;
  logic                    r_frameDone;
  logic [4*DigitCount-1:0] r_valueQ;
  logic [DigitCount-1:0]   r_dpQ;
  logic [DigitCount-1:0]   r_enQ;
  logic                    r_lzbQ;
  logic [3:0]              r_brightQ;

  logic [3:0]              w_digit;
  logic                    w_dpReq;
  logic                    w_blank;
  logic                    w_allZero;
  logic [CntW+4:0]         w_dwellScaled;
  logic [CntW+4:0]         w_dutyLimit;
  logic                    w_lit;

  // Active-low segment pattern {g,f,e,d,c,b,a} for one hex nibble
  function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
    case (nib)
      4'h0:    hexToSeg = 7'b1000000;
      4'h1:    hexToSeg = 7'b1111001;
      4'h2:    hexToSeg = 7'b0100100;
      4'h3:    hexToSeg = 7'b0110000;
      4'h4:    hexToSeg = 7'b0011001;
      4'h5:    hexToSeg = 7'b0010010;
      4'h6:    hexToSeg = 7'b0000010;
      4'h7:    hexToSeg = 7'b1111000;
      4'h8:    hexToSeg = 7'b0000000;
      4'h9:    hexToSeg = 7'b0010000;
      4'hA:    hexToSeg = 7'b0001000;
      4'hB:    hexToSeg = 7'b0000011;
      4'hC:    hexToSeg = 7'b1000110;
      4'hD:    hexToSeg = 7'b0100001;
      4'hE:    hexToSeg = 7'b0000110;
      default: hexToSeg = 7'b0001110;
    endcase
  endfunction

  // Scan sequencer: the start-up edge arms scanning and takes the first
  // snapshot. After that, the dwell counter steps the digit selector, and
  // each frame wrap reloads the snapshots and pulses FrameDone.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_running   <= 1'b0;
      r_dwell     <= '0;
      r_sel       <= '0;
      r_frameDone <= 1'b0;
      r_valueQ    <= '0;
      r_dpQ       <= '0;
      r_enQ       <= '0;
      r_lzbQ      <= 1'b0;
      r_brightQ   <= '0;
    end else if (!r_running) begin
      r_running   <= 1'b1;
      r_frameDone <= 1'b0;
      r_valueQ    <= Value;
      r_dpQ       <= DpIn;
      r_enQ       <= DigitEnable;
      r_lzbQ      <= LeadingZeroBlank;
      r_brightQ   <= Brightness;
    end else if (r_dwell == LastDwell) begin
      r_dwell <= '0;
      if (r_sel == LastSel) begin
        r_sel       <= '0;
        r_frameDone <= 1'b1;
        r_valueQ    <= Value;
        r_dpQ       <= DpIn;
        r_enQ       <= DigitEnable;
        r_lzbQ      <= LeadingZeroBlank;
        r_brightQ   <= Brightness;
      end else begin
        r_sel       <= r_sel + 1'b1;
        r_frameDone <= 1'b0;
      end
    end else begin
      r_dwell     <= r_dwell + 1'b1;
      r_frameDone <= 1'b0;
    end
  end

  // Select the current nibble and decide whether the digit is blanked.
  // The loop walks from the top digit down while accumulating "everything
  // from here upward is zero". That flag decides leading-zero suppression
  // for any digit except digit 0.
  always_comb begin
    w_digit   = 4'h0;
    w_dpReq   = 1'b0;
    w_blank   = 1'b1;
    w_allZero = 1'b1;
    for (int k = DigitCount - 1; k >= 0; k--) begin
      w_allZero = w_allZero && (r_valueQ[4*k +: 4] == 4'h0);
      if (r_sel == SelW'(k)) begin
        w_digit = r_valueQ[4*k +: 4];
        w_dpReq = r_dpQ[k];
        w_blank = !r_enQ[k] || (r_lzbQ && (k != 0) && w_allZero);
      end
    end
  end

  // Brightness duty: light the digit while dwell*16 < ScanCycles*(level+1),
  // evaluated wide enough that the full-scale product never truncates
  always_comb begin
    w_dwellScaled = {1'b0, r_dwell, 4'b0000};
    w_dutyLimit   = (CntW+5)'(ScanCycles) * ((CntW+5)'(r_brightQ) + (CntW+5)'(1));
    w_lit         = r_running && !w_blank && (w_dwellScaled < w_dutyLimit);
  end

  // Pin drive: at most one anode low, and everything dark when not lit
  always_comb begin
    AN  = '1;
    Seg = 7'h7F;
    Dp  = 1'b1;
    if (w_lit) begin
      Seg = hexToSeg(w_digit);
      Dp  = !w_dpReq;
      for (int k = 0; k < DigitCount; k++) begin
        if (r_sel == SelW'(k)) begin
          AN[k] = 1'b0;
        end
      end
    end
  end

  assign Selector  = r_sel;
  assign FrameDone = r_frameDone;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner (4 digits, 4-cycle dwell).
// A behavioural model derives every output from the edge count since reset
// release plus the inputs captured at frame boundaries. A negedge compare
// process checks the DUT against that model on every cycle. Directed
// sections pin the model with hand-computed literal values.
module tb_seven_segment_scanner;

  localparam int DigitCount = 4;
  localparam int ScanCycles = 4;
  localparam int FrameLen   = DigitCount * ScanCycles;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] Value = 16'h0;
  logic [3:0]  DpIn = 4'h0;
  logic [3:0]  DigitEnable = 4'hF;
  logic        LeadingZeroBlank = 1'b0;
  logic [3:0]  Brightness = 4'hF;
  logic [3:0]  AN;
  logic [6:0]  Seg;
  logic        Dp;
  logic [1:0]  Selector;
  logic        FrameDone;

  int checks = 0;
  int passes = 0;

  // Model state: edges since release, and the frame-captured inputs
  int          n = 0;
  logic [15:0] mVal = '0;
  logic [3:0]  mDp = '0;
  logic [3:0]  mEn = '0;
  logic        mLzb = 1'b0;
  int          mB = 0;

  logic [6:0] hexSeg [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  seven_segment_scanner #(.DigitCount(DigitCount), .ScanCycles(ScanCycles)) dut (
    .Clk(Clk), .Reset(Reset), .Value(Value), .DpIn(DpIn),
    .DigitEnable(DigitEnable), .LeadingZeroBlank(LeadingZeroBlank),
    .Brightness(Brightness), .AN(AN), .Seg(Seg), .Dp(Dp),
    .Selector(Selector), .FrameDone(FrameDone)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic stepEdges(input int k);
    repeat (k) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic waitFrame();
    int budget;
    budget = 0;
    do begin
      @(posedge Clk);
      #1;
      budget++;
    end while (!FrameDone && budget < 2 * FrameLen);
    checkOutput("frame wait", int'(FrameDone), 1);
  endtask

  // Model: count edges since release and capture inputs on edge 1 and
  // on every edge that starts a new frame
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      n = 0;
    end else begin
      n++;
      if ((n - 1) % FrameLen == 0) begin
        mVal = Value;
        mDp  = DpIn;
        mEn  = DigitEnable;
        mLzb = LeadingZeroBlank;
        mB   = int'(Brightness);
      end
    end
  end

  // Compare the DUT against the model on every falling edge
  always @(negedge Clk) begin
    int eAN, eSeg, eDp, eSel, eFd, dwell, sel, litCycles;
    bit blank, lit;
    eAN = 15; eSeg = 'h7F; eDp = 1; eSel = 0; eFd = 0;
    if (Reset && n > 0) begin
      dwell     = (n - 1) % ScanCycles;
      sel       = ((n - 1) / ScanCycles) % DigitCount;
      eSel      = sel;
      eFd       = (n > 1 && (n - 1) % FrameLen == 0) ? 1 : 0;
      blank     = !mEn[sel] || (mLzb && sel >= 1 && (int'(mVal) >> (4 * sel)) == 0);
      litCycles = (ScanCycles * (mB + 1) + 15) / 16;
      if (litCycles < 1) litCycles = 1;
      lit       = !blank && dwell < litCycles;
      if (lit) begin
        eAN  = 15 ^ (1 << sel);
        eSeg = int'(hexSeg[(int'(mVal) >> (4 * sel)) & 15]);
        eDp  = mDp[sel] ? 0 : 1;
      end
    end
    checkOutput("model AN", int'(AN), eAN);
    checkOutput("model Seg", int'(Seg), eSeg);
    checkOutput("model Dp", int'(Dp), eDp);
    checkOutput("model Selector", int'(Selector), eSel);
    checkOutput("model FrameDone", int'(FrameDone), eFd);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed literal scenarios, then randomized traffic
  initial begin
    logic [6:0] bootSeg [4];
    int sel;
    bootSeg = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};

    Value = 16'h1234;
    #12;
    checkOutput("reset AN", int'(AN), 'hF);
    checkOutput("reset Seg", int'(Seg), 'h7F);
    @(negedge Clk) Reset = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(posedge Clk);
      #1;
      sel = ((i - 1) / 4) % 4;
      checkOutput("boot AN", int'(AN), 15 ^ (1 << sel));
      checkOutput("boot Seg", int'(Seg), int'(bootSeg[sel]));
      checkOutput("boot FrameDone", int'(FrameDone), (i == 17) ? 1 : 0);
    end

    // Mid-frame value change stays hidden until the wrap
    stepEdges(6);
    Value = 16'hABCD;
    stepEdges(2);
    checkOutput("old value held", int'(Seg), 'b0110000);
    waitFrame();
    checkOutput("new digit0 D", int'(Seg), 'b0100001);
    stepEdges(4);
    checkOutput("new digit1 C", int'(Seg), 'b1000110);

    // Leading-zero suppression
    LeadingZeroBlank = 1'b1;
    Value = 16'h0050;
    waitFrame();
    checkOutput("lzb d0 AN", int'(AN), 'b1110);
    checkOutput("lzb d0 Seg", int'(Seg), 'b1000000);
    stepEdges(4);
    checkOutput("lzb d1 AN", int'(AN), 'b1101);
    checkOutput("lzb d1 Seg", int'(Seg), 'b0010010);
    stepEdges(4);
    checkOutput("lzb d2 AN", int'(AN), 'hF);
    checkOutput("lzb d2 Seg", int'(Seg), 'h7F);
    stepEdges(4);
    checkOutput("lzb d3 AN", int'(AN), 'hF);
    Value = 16'h0000;
    waitFrame();
    checkOutput("lzb zero d0 AN", int'(AN), 'b1110);
    checkOutput("lzb zero d0 Seg", int'(Seg), 'b1000000);
    stepEdges(4);
    checkOutput("lzb zero d1 AN", int'(AN), 'hF);

    // Digit enables and decimal points
    LeadingZeroBlank = 1'b0;
    Value = 16'h1234;
    DigitEnable = 4'b1010;
    DpIn = 4'b0010;
    waitFrame();
    checkOutput("en d0 AN", int'(AN), 'hF);
    checkOutput("en d0 Dp", int'(Dp), 1);
    stepEdges(4);
    checkOutput("en d1 AN", int'(AN), 'b1101);
    checkOutput("en d1 Dp", int'(Dp), 0);
    checkOutput("en d1 Seg", int'(Seg), 'b0110000);
    stepEdges(4);
    checkOutput("en d2 AN", int'(AN), 'hF);

    // Brightness duty
    DigitEnable = 4'hF;
    DpIn = 4'h0;
    Brightness = 4'd7;
    waitFrame();
    checkOutput("b7 dwell0", int'(AN), 'b1110);
    stepEdges(1);
    checkOutput("b7 dwell1", int'(AN), 'b1110);
    stepEdges(1);
    checkOutput("b7 dwell2", int'(AN), 'hF);
    stepEdges(1);
    checkOutput("b7 dwell3", int'(AN), 'hF);
    Brightness = 4'd0;
    waitFrame();
    checkOutput("b0 dwell0", int'(AN), 'b1110);
    stepEdges(1);
    checkOutput("b0 dwell1", int'(AN), 'hF);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        for (int k = 0; k < 4; k++)
          Value[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
        DpIn             = 4'($urandom);
        DigitEnable      = 4'($urandom);
        LeadingZeroBlank = 1'($urandom);
        Brightness       = 4'($urandom);
      end
      stepEdges(1);
    end

    // Reset mid-frame, then again at edge 6 of the restarted scan
    Brightness = 4'hF;
    DigitEnable = 4'hF;
    LeadingZeroBlank = 1'b0;
    Value = 16'h1234;
    stepEdges(7);
    #1 Reset = 1'b0;
    #1;
    checkOutput("async reset AN", int'(AN), 'hF);
    checkOutput("async reset Seg", int'(Seg), 'h7F);
    @(negedge Clk) Reset = 1'b1;
    stepEdges(6);
    #1 Reset = 1'b0;
    #1;
    checkOutput("edge6 reset AN", int'(AN), 'hF);
    checkOutput("edge6 reset Dp", int'(Dp), 1);
    @(negedge Clk) Reset = 1'b1;
    stepEdges(1);
    checkOutput("restart AN", int'(AN), 'b1110);
    checkOutput("restart Seg", int'(Seg), 'b0011001);
    checkOutput("restart Selector", int'(Selector), 0);
    checkOutput("restart FrameDone", int'(FrameDone), 0);
    stepEdges(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
